// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between the requesting cache controllers and the
// round-robin arbiter. The master side drives requests; the slave side
// (the arbiter) returns a registered one-hot grant with its binary index.
interface rr_onehot_arbiter_if #(
  parameter int unsigned WIDTH = 16
);

  localparam int unsigned IW = $clog2(WIDTH);

  logic [WIDTH-1:0] request;
  logic [WIDTH-1:0] grant;
  logic [IW-1:0]    grant_index;
  logic             grant_valid;

  modport master (
    output request,
    input  grant,
    input  grant_index,
    input  grant_valid
  );

  modport slave (
    input  request,
    output grant,
    output grant_index,
    output grant_valid
  );

endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter for the shared main-memory port.
// A grant is held for as long as its owner keeps requesting; on release the
// priority pointer moves to the requester after the owner, and one idle
// cycle separates consecutive grants. All outputs are registered.
module rr_onehot_arbiter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  rr_onehot_arbiter_if.slave  bus
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    pointer_q, pointer_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] grant_q, grant_d;
  logic [IW-1:0]    grant_index_q, grant_index_d;
  logic             grant_valid_q, grant_valid_d;

  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    cand;

  // Scan pointer, pointer+1, ... with natural IW-bit wrap; first set bit wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      cand = pointer_q + IW'(k);
      if (!pick_found && bus.request[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic: arbitrate in IDLE, hold or release in GRANTED.
  always_comb begin
    state_d       = state_q;
    pointer_d     = pointer_q;
    owner_d       = owner_q;
    grant_d       = grant_q;
    grant_index_d = grant_index_q;
    grant_valid_d = grant_valid_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          grant_index_d     = pick_idx;
          grant_valid_d     = 1'b1;
          state_d           = GRANTED;
        end else begin
          grant_d       = '0;
          grant_index_d = '0;
          grant_valid_d = 1'b0;
        end
      end

      GRANTED: begin
        // No preemption: only the owner's own request bit matters here.
        if (!bus.request[owner_q]) begin
          grant_d       = '0;
          grant_index_d = '0;
          grant_valid_d = 1'b0;
          pointer_d     = owner_q + IW'(1);
          state_d       = IDLE;
        end
      end

      default: begin
        state_d       = IDLE;
        grant_d       = '0;
        grant_index_d = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything without a clock edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pointer_q     <= '0;
      owner_q       <= '0;
      grant_q       <= '0;
      grant_index_q <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pointer_q     <= pointer_d;
      owner_q       <= owner_d;
      grant_q       <= grant_d;
      grant_index_q <= grant_index_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_index = grant_index_q;
  assign bus.grant_valid = grant_valid_q;

endmodule
